// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: pin sync + clock glitch filter, 11-bit frame deframer,
// E0/F0 prefix folding and a show-ahead FIFO of {ext, brk, code} key events.
module ps2_kbd_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          clock_50,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  input  logic                          rd_en,
  output logic                          valid,
  output logic [7:0]                    code,
  output logic                          ext,
  output logic                          brk,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } entry_t;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // ---------------- input synchronisers and clock filter ----------------
  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] filt_cnt;
  logic          sample;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // filt_cnt counts prior disagreeing samples; the FILTER_LEN-th one flips clk_f
  always_ff @(posedge clock_50) begin
    if (reset) begin
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_f_d <= clk_f;
      if (clk_s2 != clk_f) begin
        if (filt_cnt == FILT_MAX) begin
          clk_f    <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign sample = clk_f_d & ~clk_f;

  // ---------------- frame FSM ----------------
  state_t        state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          start_en, shift_en, par_en, stop_en, in_frame;
  logic          tmo_hit, frame_ok;

  always_ff @(posedge clock_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample && !dat_s2)           state_nxt = DATA;
      DATA:    if (sample && bit_cnt == 3'd7)   state_nxt = PARITY;
      PARITY:  if (sample)                      state_nxt = STOP;
      STOP:    if (sample)                      state_nxt = IDLE;
      default:                                  state_nxt = IDLE;
    endcase
    if (tmo_hit) state_nxt = IDLE;
  end

  always_comb begin
    start_en = (state == IDLE)   && sample && !dat_s2;
    shift_en = (state == DATA)   && sample;
    par_en   = (state == PARITY) && sample;
    stop_en  = (state == STOP)   && sample;
    in_frame = (state != IDLE);
  end

  assign tmo_hit  = in_frame && !sample && (tmo_cnt == TMO_MAX);
  assign frame_ok = dat_s2 && (^{shreg, par_bit});

  logic       rx_vld;
  logic [7:0] rx_byte;

  always_ff @(posedge clock_50) begin
    if (reset) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tmo_cnt   <= '0;
      rx_vld    <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      if (start_en)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg   <= {dat_s2, shreg[7:1]};
      if (par_en)   par_bit <= dat_s2;
      tmo_cnt   <= (!in_frame || sample) ? '0 : tmo_cnt + TW'(1);
      rx_vld    <= stop_en && frame_ok;
      if (stop_en) rx_byte <= shreg;
      frame_err <= (stop_en && !frame_ok) || tmo_hit;
    end
  end

  // ---------------- prefix folding ----------------
  logic pend_ext, pend_brk;
  logic is_e0, is_f0, push;

  assign is_e0 = (rx_byte == 8'hE0);
  assign is_f0 = (rx_byte == 8'hF0);
  assign push  = rx_vld && !is_e0 && !is_f0;

  always_ff @(posedge clock_50) begin
    if (reset || tmo_hit) begin
      pend_ext <= 1'b0;
      pend_brk <= 1'b0;
    end else if (rx_vld) begin
      if (is_e0) begin
        pend_ext <= 1'b1;
      end else if (is_f0) begin
        pend_brk <= 1'b1;
      end else begin
        pend_ext <= 1'b0;
        pend_brk <= 1'b0;
      end
    end
  end

  // ---------------- event FIFO ----------------
  entry_t          mem [FIFO_DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, do_pop, do_push;

  assign full    = (level == DEPTH);
  assign valid   = (level != '0);
  assign do_pop  = rd_en && valid;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock_50) begin
    if (do_push) mem[wr_ptr] <= '{ext: pend_ext, brk: pend_brk, code: rx_byte};
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  assign head = mem[rd_ptr];
  assign code = valid ? head.code : 8'h00;
  assign ext  = valid && head.ext;
  assign brk  = valid && head.brk;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Randomised bench for ps2_kbd_rx_fifo: drives PS/2 frames on the pins and
// compares the FIFO against a queue model of prefix folding and buffering.
module tb_ps2_kbd_rx_fifo;
  localparam int FL  = 8;
  localparam int FD  = 8;
  localparam int TMO = 2000;

  logic       clock_50 = 1'b0;
  logic       reset, ps2_clk, ps2_dat, rd_en;
  logic       valid, ext, brk, overflow, frame_err;
  logic [7:0] code;
  logic [$clog2(FD):0] level;

  ps2_kbd_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TMO)) dut (
    .clock_50(clock_50), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_en(rd_en), .valid(valid), .code(code), .ext(ext), .brk(brk),
    .level(level), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clock_50 = ~clock_50;

  int unsigned cyc = 0;
  always @(posedge clock_50) cyc <= cyc + 1;

  int   err_hi = 0, err_rise = 0;
  logic err_prev = 1'b0;
  always @(negedge clock_50) begin
    if (frame_err) err_hi <= err_hi + 1;
    if (frame_err && !err_prev) err_rise <= err_rise + 1;
    err_prev <= frame_err;
  end

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: queue of {ext,brk,code}
  logic [9:0] mq[$];
  bit m_pe, m_pb, m_ovf;

  function automatic void m_rx(input logic [7:0] b);
    if (b == 8'hE0) m_pe = 1;
    else if (b == 8'hF0) m_pb = 1;
    else begin
      if (mq.size() < FD) mq.push_back({m_pe, m_pb, b});
      else m_ovf = 1;
      m_pe = 0;
      m_pb = 0;
    end
  endfunction

  function automatic void m_clear();
    mq.delete();
    m_pe = 0; m_pb = 0; m_ovf = 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock_50);
    #1;
  endtask

  task automatic bit_fall(input logic b);
    tick(20); ps2_dat = b; tick(20); ps2_clk = 1'b0;
  endtask

  task automatic bit_rise();
    tick(40); ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0, input bit bad_stop = 0);
    logic [10:0] f;
    f = mk_frame(b, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) begin bit_fall(f[i]); bit_rise(); end
    tick(30); ps2_dat = 1'b1;
    if (!bad_par && !bad_stop) m_rx(b);
  endtask

  task automatic check_state();
    @(negedge clock_50);
    chk("valid", valid, mq.size() != 0);
    chk("level", level, mq.size());
    chk("overflow", overflow, m_ovf);
    if (mq.size() != 0) chk("head", {ext, brk, code}, mq[0]);
    else                chk("empty_head", {ext, brk, code}, 10'h0);
  endtask

  task automatic pop_one();
    @(negedge clock_50);
    if (mq.size() != 0) chk("pop_head", {ext, brk, code}, mq[0]);
    rd_en = 1'b1;
    @(posedge clock_50); #1;
    rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(3); reset = 1'b0; tick(2);
    m_clear();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    int unsigned t0;
    int lat, e0, h0;
    reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; rd_en = 1'b0;
    m_clear();
    tick(5);
    check_state();
    chk("rst_frame_err", frame_err, 1'b0);
    reset = 1'b0; tick(5);

    // single frame 0x1C, measure stop-edge to valid latency
    f = mk_frame(8'h1C, 0, 0);
    for (int i = 0; i < 10; i++) begin bit_fall(f[i]); bit_rise(); end
    bit_fall(f[10]);
    t0 = cyc; lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock_50);
      if (valid) begin lat = int'(cyc - t0); break; end
    end
    chk("push_latency", lat, FL + 4);
    bit_rise(); tick(30);
    m_rx(8'h1C);
    check_state();
    chk("t1_code", code, 8'h1C);
    pop_one(); check_state();

    // prefix folding
    send_frame(8'hF0); send_frame(8'h1C);
    send_frame(8'hE0); send_frame(8'hF0); send_frame(8'h75);
    check_state();
    chk("t2_entry0", {ext, brk, code}, 10'h11C);
    pop_one();
    @(negedge clock_50);
    chk("t2_entry1", {ext, brk, code}, 10'h375);
    pop_one(); check_state();

    // bad parity
    e0 = err_rise; h0 = err_hi;
    send_frame(8'h1C, 1, 0);
    chk("perr_pulses", err_rise - e0, 1);
    chk("perr_width", err_hi - h0, 1);
    check_state();
    send_frame(8'h23); check_state(); pop_one();

    // overflow
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i));
    check_state();
    chk("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) pop_one();
    check_state();
    do_reset(); check_state();

    // timeout with a pending E0 that must be forgotten
    send_frame(8'hE0);
    e0 = err_rise;
    f = mk_frame(8'hA5, 0, 0);
    for (int i = 0; i < 4; i++) begin bit_fall(f[i]); bit_rise(); end
    bit_fall(f[4]);
    t0 = cyc; lat = -1;
    for (int k = 0; k < TMO + 200; k++) begin
      @(negedge clock_50);
      if (frame_err) begin lat = int'(cyc - t0); break; end
    end
    chk("tmo_latency", lat, TMO + FL + 3);
    bit_rise(); ps2_dat = 1'b1; tick(20);
    m_pe = 0; m_pb = 0;
    chk("tmo_pulses", err_rise - e0, 1);

    // clock glitch shorter than the filter, with data low
    e0 = err_rise;
    ps2_dat = 1'b0; tick(5); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(5); ps2_dat = 1'b1; tick(40);
    send_frame(8'h29); check_state();
    chk("glitch_no_err", err_rise - e0, 0);
    pop_one();
    pop_one(); check_state();

    // full FIFO with push and pop in the same cycle
    for (int i = 0; i < 8; i++) send_frame(8'h30 + 8'(i));
    check_state();
    f = mk_frame(8'h5A, 0, 0);
    for (int i = 0; i < 10; i++) begin bit_fall(f[i]); bit_rise(); end
    bit_fall(f[10]);
    tick(FL + 3);
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    void'(mq.pop_front()); m_rx(8'h5A);
    bit_rise(); tick(30);
    check_state();
    for (int i = 0; i < 7; i++) pop_one();
    @(negedge clock_50);
    chk("sim_tail", code, 8'h5A);
    pop_one(); check_state();

    // reset mid-frame
    f = mk_frame(8'h77, 0, 0);
    for (int i = 0; i < 5; i++) begin bit_fall(f[i]); bit_rise(); end
    do_reset(); tick(20);
    send_frame(8'h1C); check_state();
    pop_one(); check_state();

    // randomised traffic
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      bit bp, bs;
      case ($urandom % 8)
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        default: begin b = 8'($urandom); if (b == 8'hE0 || b == 8'hF0) b = b ^ 8'h01; end
      endcase
      bp = 0; bs = 0;
      if ($urandom % 6 == 0) begin if ($urandom % 2) bp = 1; else bs = 1; end
      e0 = err_rise;
      send_frame(b, bp, bs);
      chk("rnd_err", err_rise - e0, (bp || bs) ? 1 : 0);
      check_state();
      if ($urandom % 3 == 0) pop_one();
    end
    while (mq.size() != 0) pop_one();
    check_state();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
